// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: takes exceptions and interrupts from EX.
// It writes the trap CSRs, then redirects the PC to mtvec. MRET restores MIE and jumps to mepc.
module trap_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_addr_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        illegal_i,
    input  logic        mret_i,
    input  logic        ext_irq_i,
    input  logic        timer_irq_i,
    input  logic [31:0] r_mstatus_i,
    input  logic [31:0] r_mepc_i,
    input  logic [31:0] r_mtvec_i,
    input  logic [31:0] r_mie_i,
    output logic        w_enable_o,
    output logic        w_ctrl_enable_o,
    output logic [31:0] w_mstatus_o,
    output logic [31:0] w_mepc_o,
    output logic [31:0] w_mie_o,
    output logic [31:0] w_mcause_o,
    output logic        hold_o,
    output logic        flush_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o
);

    localparam logic [31:0] CauseEcall   = 32'h0000_000B;
    localparam logic [31:0] CauseEbreak  = 32'h0000_0003;
    localparam logic [31:0] CauseIllegal = 32'h0000_0002;
    localparam logic [31:0] CauseExtIrq  = 32'h8000_000B;
    localparam logic [31:0] CauseTmrIrq  = 32'h8000_0007;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StTrapWr  = 3'd1,
        StTrapJmp = 3'd2,
        StMretWr  = 3'd3,
        StMretJmp = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;

    logic ext_ok, tmr_ok, trap_take, accept;

    assign ext_ok = ext_irq_i & r_mstatus_i[3] & r_mie_i[11];
    assign tmr_ok = timer_irq_i & r_mstatus_i[3] & r_mie_i[7];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cause_q <= 32'h0;
            epc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cause_d         = cause_q;
        epc_d           = epc_q;
        trap_take       = 1'b0;
        accept          = 1'b0;
        w_enable_o      = 1'b0;
        w_ctrl_enable_o = 1'b0;
        w_mstatus_o     = 32'h0;
        w_mepc_o        = 32'h0;
        w_mie_o         = 32'h0;
        w_mcause_o      = 32'h0;
        hold_o          = 1'b0;
        flush_o         = 1'b0;
        jump_o          = 1'b0;
        jump_addr_o     = 32'h0;

        unique case (state_q)
            StIdle: begin
                // Gated by rst_n so hold stays low while reset is asserted.
                if (rst_n && inst_valid_i) begin
                    accept = 1'b1;
                    if (illegal_i) begin
                        cause_d   = CauseIllegal;
                        trap_take = 1'b1;
                    end else if (ecall_i) begin
                        cause_d   = CauseEcall;
                        trap_take = 1'b1;
                    end else if (ebreak_i) begin
                        cause_d   = CauseEbreak;
                        trap_take = 1'b1;
                    end else if (mret_i) begin
                        state_d = StMretWr;
                    end else if (ext_ok) begin
                        cause_d   = CauseExtIrq;
                        trap_take = 1'b1;
                    end else if (tmr_ok) begin
                        cause_d   = CauseTmrIrq;
                        trap_take = 1'b1;
                    end else begin
                        accept = 1'b0;
                    end
                end
                if (trap_take) begin
                    state_d = StTrapWr;
                    epc_d   = inst_addr_i;
                end
                hold_o  = accept;
                flush_o = accept;
            end
            StTrapWr: begin
                w_enable_o      = 1'b1;
                w_ctrl_enable_o = 1'b1;
                w_mepc_o        = epc_q;
                w_mcause_o      = cause_q;
                w_mie_o         = r_mie_i;
                w_mstatus_o     = r_mstatus_i;
                w_mstatus_o[7]  = r_mstatus_i[3];
                w_mstatus_o[3]  = 1'b0;
                w_mstatus_o[12:11] = 2'b11;
                hold_o          = 1'b1;
                state_d         = StTrapJmp;
            end
            StTrapJmp: begin
                jump_o      = 1'b1;
                flush_o     = 1'b1;
                hold_o      = 1'b1;
                jump_addr_o = {r_mtvec_i[31:2], 2'b00};
                state_d     = StIdle;
            end
            StMretWr: begin
                w_enable_o      = 1'b1;
                w_ctrl_enable_o = 1'b1;
                w_mepc_o        = r_mepc_i;
                w_mcause_o      = cause_q;
                w_mie_o         = r_mie_i;
                w_mstatus_o     = r_mstatus_i;
                w_mstatus_o[3]  = r_mstatus_i[7];
                w_mstatus_o[7]  = 1'b1;
                hold_o          = 1'b1;
                state_d         = StMretJmp;
            end
            StMretJmp: begin
                jump_o      = 1'b1;
                flush_o     = 1'b1;
                hold_o      = 1'b1;
                jump_addr_o = r_mepc_i;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
